m_sub64_pipe: RTL and testbench

//  Two-stage pipelined subtractor, the inverse counterpart of the 64-bit carry-select adder.

---
 rtl/m_sub64_pipe.sv | 121 ++++++++++++
 tb/tb_m_sub64_pipe.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/m_sub64_pipe.sv
// Two-stage pipelined subtractor: D = A + ~B + ~bIn using 4-bit carry-select blocks.
// Low half resolves in stage 1, high half in stage 2; valid/ready on both sides.
`timescale 1ns/1ps
module m_sub64_pipe #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned BLK   = 4
) (
    input  logic             i_clk_1,
    input  logic             i_rst_1,
    input  logic             i_valid_1,
    output logic             o_ready_1,
    input  logic [WIDTH-1:0] i_subOperand1,
    input  logic [WIDTH-1:0] i_subOperand2,
    input  logic             i_bIn_1,
    output logic             o_valid_1,
    input  logic             i_ready_1,
    output logic [WIDTH-1:0] o_subDiff,
    output logic             o_bOut_1,
    output logic             o_ovf_1,
    output logic             o_zero_1
);

    localparam int unsigned HALF = WIDTH / 2;
    localparam int unsigned NBLK = HALF / BLK;

    // Returns {carry_out, sum}; each block precomputes both carry-in cases, ripple selects.
    function automatic logic [HALF:0] f_csel(input logic [HALF-1:0] a,
                                             input logic [HALF-1:0] b,
                                             input logic            cin);
        logic [HALF-1:0] sum;
        logic [BLK:0]    s0;
        logic [BLK:0]    s1;
        logic            c;
        sum = '0;
        c   = cin;
        for (int k = 0; k < NBLK; k++) begin
            s0 = {1'b0, a[k*BLK +: BLK]} + {1'b0, b[k*BLK +: BLK]};
            s1 = s0 + {{BLK{1'b0}}, 1'b1};
            sum[k*BLK +: BLK] = c ? s1[BLK-1:0] : s0[BLK-1:0];
            c = c ? s1[BLK] : s0[BLK];
        end
        return {c, sum};
    endfunction

    logic [WIDTH-1:0] w_b_inv;
    logic [HALF:0]    w_lo;
    logic [HALF:0]    w_hi;
    logic [WIDTH-1:0] w_diff;
    logic             w_ovf;
    logic             w_adv2;
    logic             w_acc;

    logic             r_s1_valid;
    logic [HALF-1:0]  r_s1_lo;
    logic             r_s1_c;
    logic [HALF-1:0]  r_s1_a_hi;
    logic [HALF-1:0]  r_s1_bn_hi;

    logic             r_s2_valid;
    logic [WIDTH-1:0] r_s2_diff;
    logic             r_s2_bout;
    logic             r_s2_ovf;
    logic             r_s2_zero;

    always_comb begin
        w_b_inv = ~i_subOperand2;
        w_lo    = f_csel(i_subOperand1[HALF-1:0], w_b_inv[HALF-1:0], ~i_bIn_1);
        w_hi    = f_csel(r_s1_a_hi, r_s1_bn_hi, r_s1_c);
        w_diff  = {w_hi[HALF-1:0], r_s1_lo};
        // sign(B) is the inverse of the stored ~B msb
        w_ovf   = (r_s1_a_hi[HALF-1] == r_s1_bn_hi[HALF-1]) &&
                  (w_diff[WIDTH-1] != r_s1_a_hi[HALF-1]);
        w_adv2  = r_s1_valid & (~r_s2_valid | i_ready_1);
        w_acc   = i_valid_1 & o_ready_1;
    end

    assign o_ready_1 = ~r_s1_valid | w_adv2;

    always_ff @(posedge i_clk_1 or posedge i_rst_1) begin
        if (i_rst_1) begin
            r_s1_valid <= 1'b0;
            r_s1_lo    <= '0;
            r_s1_c     <= 1'b0;
            r_s1_a_hi  <= '0;
            r_s1_bn_hi <= '0;
        end else if (w_acc) begin
            r_s1_valid <= 1'b1;
            r_s1_lo    <= w_lo[HALF-1:0];
            r_s1_c     <= w_lo[HALF];
            r_s1_a_hi  <= i_subOperand1[WIDTH-1:HALF];
            r_s1_bn_hi <= w_b_inv[WIDTH-1:HALF];
        end else if (w_adv2) begin
            r_s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge i_clk_1 or posedge i_rst_1) begin
        if (i_rst_1) begin
            r_s2_valid <= 1'b0;
            r_s2_diff  <= '0;
            r_s2_bout  <= 1'b0;
            r_s2_ovf   <= 1'b0;
            r_s2_zero  <= 1'b0;
        end else if (w_adv2) begin
            r_s2_valid <= 1'b1;
            r_s2_diff  <= w_diff;
            r_s2_bout  <= ~w_hi[HALF];
            r_s2_ovf   <= w_ovf;
            r_s2_zero  <= (w_diff == '0);
        end else if (i_ready_1) begin
            r_s2_valid <= 1'b0;
        end
    end

    assign o_valid_1 = r_s2_valid;
    assign o_subDiff = r_s2_diff;
    assign o_bOut_1  = r_s2_bout;
    assign o_ovf_1   = r_s2_ovf;
    assign o_zero_1  = r_s2_zero;

endmodule

// File: tb/tb_m_sub64_pipe.sv
// Directed self-checking bench for m_sub64_pipe: single ops, stalled stream, mid-stream reset.
`timescale 1ns/1ps
module tb_m_sub64_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [63:0] op_a;
    logic [63:0] op_b;
    logic        b_in;
    logic        in_ready;
    logic        out_valid;
    logic [63:0] diff;
    logic        b_out;
    logic        ovf;
    logic        zero;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    m_sub64_pipe #(.WIDTH(64), .BLK(4)) dut (
        .i_clk_1       (clk),
        .i_rst_1       (rst),
        .i_valid_1     (in_valid),
        .o_ready_1     (in_ready),
        .i_subOperand1 (op_a),
        .i_subOperand2 (op_b),
        .i_bIn_1       (b_in),
        .o_valid_1     (out_valid),
        .i_ready_1     (out_ready),
        .o_subDiff     (diff),
        .o_bOut_1      (b_out),
        .o_ovf_1       (ovf),
        .o_zero_1      (zero)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One op with consumer always ready; inputs driven at negedge, sampled 2ns later.
    task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic bi, input logic [63:0] ed, input logic eb,
                          input logic eo, input logic ez);
        @(negedge clk);
        in_valid = 1'b1; op_a = a; op_b = b; b_in = bi; out_ready = 1'b1;
        #2 check({tag, ".rdy"}, 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        #2 check({tag, ".lat"}, 64'(out_valid), 64'd0);
        @(negedge clk);
        #2;
        check({tag, ".vld"}, 64'(out_valid), 64'd1);
        check({tag, ".d"}, diff, ed);
        check({tag, ".bo"}, 64'(b_out), 64'(eb));
        check({tag, ".ovf"}, 64'(ovf), 64'(eo));
        check({tag, ".z"}, 64'(zero), 64'(ez));
    endtask

    logic [63:0] ea [8];
    logic [63:0] eb [8];
    logic        ebi [8];
    logic [64:0] ext;
    logic [63:0] held_d;
    logic        held_f;
    logic        have_held;
    logic        saw_block;
    int          tx;
    int          rx;
    int          first_c;
    int          last_c;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        op_a = '0; op_b = '0; b_in = 1'b0;
        #2;
        check("rst.vld", 64'(out_valid), 64'd0);
        check("rst.d", diff, 64'd0);
        check("rst.flags", {61'd0, b_out, ovf, zero}, 64'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        run_op("t1", 64'd5, 64'd3, 1'b0, 64'd2, 1'b0, 1'b0, 1'b0);
        run_op("t2", 64'd0, 64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0);
        run_op("t3", 64'h8000_0000_0000_0000, 64'd1, 1'b0,
               64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0);
        run_op("t4", 64'h0000_0001_0000_0000, 64'd1, 1'b0,
               64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0, 1'b0);
        run_op("t5a", 64'h1234, 64'h1234, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0);
        run_op("t5b", 64'h1234, 64'h1234, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1);
        run_op("t5c", 64'd5, 64'd3, 1'b1, 64'd1, 1'b0, 1'b0, 1'b0);

        // Stream of 8 ops, consumer stalls in cycles 4..6.
        for (int i = 0; i < 8; i++) begin
            ea[i]  = (i == 7) ? 64'h8000_0000_0000_0000 : 64'(i) * 64'd1000 + 64'd7;
            eb[i]  = (i == 7) ? 64'd1 : 64'd3000;
            ebi[i] = (i == 7) ? 1'b0 : 1'(i & 1);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        tx = 0; rx = 0; first_c = -1; last_c = -1; have_held = 1'b0; saw_block = 1'b0;
        for (int c = 0; c < 60 && rx < 8; c++) begin
            out_ready = !(c >= 4 && c <= 6);
            in_valid  = (tx < 8);
            if (tx < 8) begin
                op_a = ea[tx]; op_b = eb[tx]; b_in = ebi[tx];
            end
            #2;
            if (have_held) begin
                check("s6.hold_d", diff, held_d);
                check("s6.hold_f", 64'(b_out), 64'(held_f));
            end
            have_held = out_valid && !out_ready;
            held_d = diff; held_f = b_out;
            if (!in_ready) saw_block = 1'b1;
            if (out_valid && out_ready && rx < 8) begin
                ext = {1'b0, ea[rx]} - {1'b0, eb[rx]} - 65'(ebi[rx]);
                check("s6.d", diff, ext[63:0]);
                check("s6.bo", 64'(b_out), 64'(ext[64]));
                check("s6.ovf", 64'(ovf), 64'((ea[rx][63] != eb[rx][63]) &&
                                               (ext[63] != ea[rx][63])));
                if (first_c < 0) first_c = c;
                last_c = c;
                rx++;
            end
            if (in_valid && in_ready) tx++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("s6.count", 64'(rx), 64'd8);
        check("s6.span", 64'(last_c - first_c), 64'd10);
        check("s6.backpr", 64'(saw_block), 64'd1);

        // Two ops in flight, then asynchronous reset.
        out_ready = 1'b0;
        in_valid = 1'b1; op_a = 64'd100; op_b = 64'd1; b_in = 1'b0;
        @(negedge clk);
        op_a = 64'd200;
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        check("t7.full_vld", 64'(out_valid), 64'd1);
        check("t7.full_rdy", 64'(in_ready), 64'd0);
        rst = 1'b1;
        #1;
        check("t7.rst_vld", 64'(out_valid), 64'd0);
        check("t7.rst_d", diff, 64'd0);
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #2 check("t7.no_stale", 64'(out_valid), 64'd0);
        end
        run_op("t7post", 64'd10, 64'd4, 1'b0, 64'd6, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
